// File: rtl/z_buffer_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : z_buffer_mem
// Brief    : Depth-buffer responder with handshaked read/write ports and fast clear.
// Revision : 1.0
// ============================================================================
module z_buffer_mem #(
  parameter int                   Z_SIZE    = 8,
  parameter int                   X_RES     = 4,
  parameter int                   Y_RES     = 4,
  parameter int                   DEPTH     = X_RES * Y_RES,
  parameter int                   ADDR_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR = '0,
  parameter int                   READ_WAIT = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 buf_r_w,
  input  logic [ADDR_SIZE-1:0] buf_addr,
  input  logic [Z_SIZE-1:0]    buf_data_w,
  input  logic                 data_w_valid,
  output logic                 data_w_ready,
  input  logic                 data_r_ready,
  output logic                 data_r_valid,
  output logic [Z_SIZE-1:0]    buf_data_r,
  input  logic                 clear_i,
  output logic                 clear_busy_o,
  output logic                 addr_err_o
);

  localparam int                   AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]        c_last_idx  = AW'(DEPTH - 1);
  localparam logic [ADDR_SIZE-1:0] c_depth     = ADDR_SIZE'(DEPTH);
  localparam logic [3:0]           c_read_wait = 4'(READ_WAIT);
  localparam logic [Z_SIZE-1:0]    c_max_z     = '1;

  typedef enum logic [2:0] {
    S_CLEAR   = 3'd0,
    S_IDLE    = 3'd1,
    S_RD_WAIT = 3'd2,
    S_RD_RESP = 3'd3,
    S_WR_ACK  = 3'd4
  } state_t;

  state_t              r_state;
  logic [AW-1:0]       r_clr_cnt;
  logic [AW-1:0]       r_idx;
  logic                r_in_range;
  logic                r_clear_pending;
  logic [Z_SIZE-1:0]   r_wdata;
  logic [3:0]          r_wait_cnt;
  logic [Z_SIZE-1:0]   r_mem [DEPTH];

  logic [ADDR_SIZE-1:0] w_offset;
  logic                 w_in_range;
  logic                 w_take_wr;
  logic                 w_take_rd;
  logic                 w_clear_req;
  logic                 w_mem_we;
  logic [AW-1:0]        w_mem_addr;
  logic [Z_SIZE-1:0]    w_mem_data;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign w_offset    = buf_addr - BASE_ADDR;
  assign w_in_range  = (w_offset < c_depth);
  assign w_take_wr   = data_w_valid && !buf_r_w;
  assign w_take_rd   = data_r_ready && buf_r_w;
  assign w_clear_req = r_clear_pending || clear_i;

  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = r_idx;
    w_mem_data = r_wdata;
    if (r_state == S_CLEAR) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_clr_cnt;
      w_mem_data = c_max_z;
    end else if (r_state == S_WR_ACK) begin
      w_mem_we   = data_w_valid && r_in_range;
    end
  end

  // Storage deliberately has no reset; CLEAR initialises it after every reset.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state         <= S_CLEAR;
      r_clr_cnt       <= '0;
      r_clear_pending <= 1'b0;
      r_idx           <= '0;
      r_in_range      <= 1'b0;
      r_wdata         <= '0;
      r_wait_cnt      <= '0;
      data_r_valid    <= 1'b0;
      data_w_ready    <= 1'b0;
      buf_data_r      <= '0;
      addr_err_o      <= 1'b0;
      clear_busy_o    <= 1'b1;
    end else begin
      addr_err_o <= 1'b0;
      if (clear_i && (r_state != S_CLEAR)) r_clear_pending <= 1'b1;
      case (r_state)
        S_CLEAR: begin
          if (r_clr_cnt == c_last_idx) begin
            r_clr_cnt    <= '0;
            r_state      <= S_IDLE;
            clear_busy_o <= 1'b0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (w_clear_req) begin
            r_clear_pending <= 1'b0;
            clear_busy_o    <= 1'b1;
            r_state         <= S_CLEAR;
          end else if (w_take_wr || w_take_rd) begin
            r_idx      <= w_offset[AW-1:0];
            r_in_range <= w_in_range;
            r_wdata    <= buf_data_w;
            addr_err_o <= !w_in_range;
            r_wait_cnt <= '0;
            if (w_take_wr) begin
              data_w_ready <= 1'b1;
              r_state      <= S_WR_ACK;
            end else begin
              r_state <= S_RD_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          if (r_wait_cnt == c_read_wait) begin
            buf_data_r   <= r_in_range ? r_mem[r_idx] : c_max_z;
            data_r_valid <= 1'b1;
            r_state      <= S_RD_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_RD_RESP: begin
          if (data_r_ready) begin
            data_r_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        S_WR_ACK: begin
          data_w_ready <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          clear_busy_o <= 1'b1;
          r_state      <= S_CLEAR;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/z_buffer_mem.md
# z_buffer_mem

Depth-buffer responder that serves the rasteriser's depth-test memory port. It holds X_RES*Y_RES depth words in on-chip storage and answers read requests through a data_r_valid/data_r_ready handshake and write requests through a data_w_valid/data_w_ready handshake. It also runs a fast-clear sequence that sets every word to maximum depth. It sits between the z-buffer depth-test unit and the frame's depth storage and is also the bench model for that unit.

## Interface
- Z_SIZE, 8, depth word width
- X_RES, 4, horizontal resolution
- Y_RES, 4, vertical resolution
- DEPTH, X_RES*Y_RES, number of stored words
- ADDR_SIZE, 32, address width
- BASE_ADDR, 0, word address of entry 0
- READ_WAIT, 0, extra read wait cycles (0..15)
- clk_i  input  1  clock; single clock domain
- rst_ni  input  1  asynchronous, active-low reset
- buf_r_w  input  1  request type: 1 = read, 0 = write
- buf_addr  input  ADDR_SIZE  request word address
- buf_data_w  input  Z_SIZE  write data
- data_w_valid  input  1  write request valid
- data_w_ready  output  1  write accept
- data_r_ready  input  1  read request, and response accept
- data_r_valid  output  1  read data valid
- buf_data_r  output  Z_SIZE  read data
- clear_i  input  1  fast-clear request pulse
- clear_busy_o  output  1  clear sequence running
- addr_err_o  output  1  one-cycle pulse when a request address is out of range

## Operation
- Storage: DEPTH x Z_SIZE array. It has no reset.
- offset = buf_addr - BASE_ADDR, computed at ADDR_SIZE width, unsigned. The request is in range when offset < DEPTH.
- State CLEAR:
  - Entered on reset deassertion and from IDLE when clear is pending.
  - A counter runs 0..DEPTH-1 and writes {Z_SIZE{1'b1}} to one entry per cycle.
  - After entry DEPTH-1 is written, the block goes to IDLE and the counter returns to 0.
  - clear_busy_o = 1 throughout CLEAR.
- State IDLE:
  - clear_i sets a sticky clear_pending flag in any state except CLEAR. clear_i asserted during CLEAR is ignored.
  - Priority in IDLE: clear_pending first, then write (data_w_valid && !buf_r_w), then read (data_r_ready && buf_r_w).
  - When a write or read is taken, the block captures the offset, the in-range flag and buf_data_w.
- State RD_WAIT:
  - Lasts 1+READ_WAIT cycles.
  - In its last cycle the block reads the array. An out-of-range read loads {Z_SIZE{1'b1}} instead.
  - Goes to RD_RESP.
- State RD_RESP:
  - data_r_valid = 1. buf_data_r is stable while in this state.
  - Exits to IDLE on a cycle with data_r_ready = 1. data_r_valid falls on the next edge.
  - If data_r_ready is low, the block holds in RD_RESP indefinitely.
- State WR_ACK:
  - data_w_ready = 1 for exactly one cycle.
  - If data_w_valid = 1 at the end of that cycle and the address is in range, the captured data is written to the captured offset.
  - If data_w_valid has dropped, the write is discarded.
  - Always returns to IDLE.
- Out-of-range request: addr_err_o = 1 in the first cycle after acceptance. The write is dropped but still acknowledged. The read returns all-ones.
- A read in the cycle after a write to the same offset returns the new data.

## Timing
- Reset values: data_r_valid 0, data_w_ready 0, buf_data_r 0, addr_err_o 0, clear_busy_o 1, state CLEAR, counter 0, clear_pending 0.
- Reset asserted mid-transaction aborts it immediately. Any write not yet committed is lost, and a full CLEAR follows.
- Clear duration: DEPTH cycles. From the first IDLE cycle onward, clear_busy_o = 0.
- Read with the request in cycle c0:
  - RD_WAIT occupies c1..c(1+READ_WAIT).
  - data_r_valid = 1 from c(2+READ_WAIT).
  - Minimum occupancy is 3+READ_WAIT cycles including the return to IDLE.
- Write with the request in cycle c0: data_w_ready = 1 in c1, commit at the end of c1, IDLE in c2. The earliest next request is accepted in c2.
- Requests that arrive in a non-IDLE state are not taken. The initiator holds them.
- clear_i arriving in the same cycle as an IDLE request: clear wins and the request waits.
- The offset subtraction wraps modulo 2^ADDR_SIZE. An address below BASE_ADDR is therefore out of range.

## Test plan
- Reset release: clear_busy_o = 1 for 16 cycles (4x4 default), then 0. Reading offsets 0, 5 and 15 returns 8'hFF.
- Write then read: write 8'h3C to BASE_ADDR+6, then read BASE_ADDR+6. Required: data_w_ready in c1, data_r_valid in c2 of the read (READ_WAIT=0), buf_data_r = 8'h3C. Offset 7 still reads 8'hFF.
- Back-pressure: hold data_r_ready low for 5 cycles after data_r_valid rises. Required: data_r_valid and buf_data_r stay stable; one completion only when ready returns high.
- Out of range: write to BASE_ADDR+16, then read BASE_ADDR+16. Required: one addr_err_o pulse for each request, the write is acknowledged, the read returns 8'hFF, and no array entry changes.
- Clear during a read: pulse clear_i while in RD_RESP. Required: the read completes with the old value, then CLEAR runs for 16 cycles, then all entries read 8'hFF.
- With READ_WAIT=3, reset mid-write: read latency is 5 cycles to data_r_valid. Asserting rst_ni low in the WR_ACK cycle discards the write, and the entry reads 8'hFF after the clear.
